multiplexador_display: RTL and testbench

- Consumer side of the clock divider: takes the divider's slow square-wave outputs, the ~190 Hz multiplex signal and the ~0.75 Hz time signal, and runs them on the fast system clock.
- Scans a 4-digit common-anode 7-segment display from a 16-bit BCD value, one digit per multiplex rising edge.
- Provides leading-zero blanking, per-digit blink, an invalid-BCD dash, and an inter-digit guard time against ghosting.
- Sits between the vending-machine datapath (price/credit value) and the board display pins.

---
 rtl/multiplexador_display.sv | 154 +++++++++++++++
 tb/tb_multiplexador_display.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multiplexador_display.sv
// Four-digit common-anode 7-segment scanner driven by the clock divider's slow tick outputs.
// Provides frame-coherent value snapshot, leading-zero blanking, per-digit blink, BCD error dash and anti-ghost guard.
module multiplexador_display #(
    parameter int GUARD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        saida_multiplex,
    input  logic        saida_tempo,
    input  logic [15:0] valor,
    input  logic        apaga_zeros,
    input  logic [3:0]  pisca,
    input  logic [3:0]  pontos,
    output logic [3:0]  anodo,
    output logic [6:0]  segmentos,
    output logic        ponto
);

    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);

    logic        mux_s1_q, mux_s2_q, mux_s3_q;
    logic        mux_s1_d, mux_s2_d, mux_s3_d;
    logic        tempo_s1_q, tempo_s2_q, tempo_s3_q;
    logic        tempo_s1_d, tempo_s2_d, tempo_s3_d;
    logic [1:0]  indice_q, indice_d;
    logic        fase_pisca_q, fase_pisca_d;
    logic [7:0]  guarda_q, guarda_d;
    logic [15:0] snapshot_q, snapshot_d;
    logic [6:0]  segmentos_q, segmentos_d;
    logic        ponto_q, ponto_d;
    logic        apagado_q, apagado_d;

    logic        pulso_mux, pulso_tempo;
    logic [3:0]  digito;
    logic        zero_esquerda;
    logic        apagar;

    function automatic logic [6:0] decodifica(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    always_comb begin
        mux_s1_d     = saida_multiplex;
        mux_s2_d     = mux_s1_q;
        mux_s3_d     = mux_s2_q;
        tempo_s1_d   = saida_tempo;
        tempo_s2_d   = tempo_s1_q;
        tempo_s3_d   = tempo_s2_q;
        indice_d     = indice_q;
        fase_pisca_d = fase_pisca_q;
        guarda_d     = guarda_q;
        snapshot_d   = snapshot_q;
        segmentos_d  = segmentos_q;
        ponto_d      = ponto_q;
        apagado_d    = apagado_q;

        pulso_mux   = mux_s2_q & ~mux_s3_q;
        pulso_tempo = tempo_s2_q & ~tempo_s3_q;

        if (pulso_tempo) begin
            fase_pisca_d = ~fase_pisca_q;
        end

        if (pulso_mux) begin
            indice_d = indice_q + 2'd1;
            guarda_d = GUARD_LOAD;
            if (indice_q == 2'd3) begin
                snapshot_d = valor;
            end
        end else if (guarda_q != 8'd0) begin
            guarda_d = guarda_q - 8'd1;
        end

        // Blank/decode decisions look at the post-edge index, snapshot and blink phase
        case (indice_d)
            2'd0: begin
                digito        = snapshot_d[3:0];
                zero_esquerda = 1'b0;
            end
            2'd1: begin
                digito        = snapshot_d[7:4];
                zero_esquerda = (snapshot_d[15:4] == 12'h000);
            end
            2'd2: begin
                digito        = snapshot_d[11:8];
                zero_esquerda = (snapshot_d[15:8] == 8'h00);
            end
            default: begin
                digito        = snapshot_d[15:12];
                zero_esquerda = (snapshot_d[15:12] == 4'h0);
            end
        endcase

        apagar = (apaga_zeros & zero_esquerda) | (pisca[indice_d] & fase_pisca_d);

        if (pulso_mux || pulso_tempo) begin
            apagado_d   = apagar;
            segmentos_d = apagar ? 7'b1111111 : decodifica(digito);
            ponto_d     = apagar | ~pontos[indice_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_s1_q     <= 1'b0;
            mux_s2_q     <= 1'b0;
            mux_s3_q     <= 1'b0;
            tempo_s1_q   <= 1'b0;
            tempo_s2_q   <= 1'b0;
            tempo_s3_q   <= 1'b0;
            indice_q     <= 2'd0;
            fase_pisca_q <= 1'b0;
            guarda_q     <= 8'd0;
            snapshot_q   <= 16'h0000;
            segmentos_q  <= 7'b1111111;
            ponto_q      <= 1'b1;
            apagado_q    <= 1'b1;
        end else begin
            mux_s1_q     <= mux_s1_d;
            mux_s2_q     <= mux_s2_d;
            mux_s3_q     <= mux_s3_d;
            tempo_s1_q   <= tempo_s1_d;
            tempo_s2_q   <= tempo_s2_d;
            tempo_s3_q   <= tempo_s3_d;
            indice_q     <= indice_d;
            fase_pisca_q <= fase_pisca_d;
            guarda_q     <= guarda_d;
            snapshot_q   <= snapshot_d;
            segmentos_q  <= segmentos_d;
            ponto_q      <= ponto_d;
            apagado_q    <= apagado_d;
        end
    end

    // Anodes stay dark while the guard counter runs so the old segments never light the new digit
    assign anodo     = (apagado_q || (guarda_q != 8'd0)) ? 4'b1111 : ~(4'b0001 << indice_q);
    assign segmentos = segmentos_q;
    assign ponto     = ponto_q;

endmodule

// File: tb/tb_multiplexador_display.sv
// Directed bench for multiplexador_display: scan order, guard length, snapshot, blanking, blink and reset.
module tb_multiplexador_display;

    logic        clk;
    logic        rst_n;
    logic        saida_multiplex;
    logic        saida_tempo;
    logic [15:0] valor;
    logic        apaga_zeros;
    logic [3:0]  pisca;
    logic [3:0]  pontos;
    logic [3:0]  anodo;
    logic [6:0]  segmentos;
    logic        ponto;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, SD = 7'b0111111, SB = 7'b1111111;

    multiplexador_display #(.GUARD_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .saida_multiplex (saida_multiplex),
        .saida_tempo     (saida_tempo),
        .valor           (valor),
        .apaga_zeros     (apaga_zeros),
        .pisca           (pisca),
        .pontos          (pontos),
        .anodo           (anodo),
        .segmentos       (segmentos),
        .ponto           (ponto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop the selected ticks long enough to flush the synchronisers, then raise them; returns 1ns after E2
    task automatic rise(input bit m, input bit t);
        @(negedge clk);
        if (m) saida_multiplex = 1'b0;
        if (t) saida_tempo = 1'b0;
        repeat (3) @(negedge clk);
        if (m) saida_multiplex = 1'b1;
        if (t) saida_tempo = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        repeat (n) rise(1'b1, 1'b0);
    endtask

    task automatic step(input string tag, input bit t, input logic [3:0] an,
                        input logic [6:0] sg, input logic pt);
        rise(1'b1, t);
        chk({tag, " guard_start"}, {4'h0, anodo}, 8'h0F);
        repeat (3) tick();
        chk({tag, " guard_end"}, {4'h0, anodo}, 8'h0F);
        tick();
        chk({tag, " anodo"}, {4'h0, anodo}, {4'h0, an});
        chk({tag, " segmentos"}, {1'b0, segmentos}, {1'b0, sg});
        chk({tag, " ponto"}, {7'h00, ponto}, {7'h00, pt});
    endtask

    initial begin
        rst_n           = 1'b1;
        saida_multiplex = 1'b0;
        saida_tempo     = 1'b0;
        valor           = 16'h1234;
        apaga_zeros     = 1'b0;
        pisca           = 4'b0000;
        pontos          = 4'b0100;
        #2 rst_n = 1'b0;
        #1;
        chk("reset anodo", {4'h0, anodo}, 8'h0F);
        chk("reset segmentos", {1'b0, segmentos}, {1'b0, SB});
        chk("reset ponto", {7'h00, ponto}, 8'h01);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // First frame still uses the cleared snapshot, then 1234 appears after the wrap
        step("p1",  1'b0, 4'b1101, S0, 1'b1);
        step("p2",  1'b0, 4'b1011, S0, 1'b0);
        step("p3",  1'b0, 4'b0111, S0, 1'b1);
        step("p4",  1'b0, 4'b1110, S4, 1'b1);
        step("p5",  1'b0, 4'b1101, S3, 1'b1);
        step("p6",  1'b0, 4'b1011, S2, 1'b0);
        step("p7",  1'b0, 4'b0111, S1, 1'b1);
        step("p8",  1'b0, 4'b1110, S4, 1'b1);

        // Sync latency and single advance for a long-held high level
        @(negedge clk) saida_multiplex = 1'b0;
        repeat (3) @(negedge clk);
        saida_multiplex = 1'b1;
        tick();
        tick();
        chk("e1 anodo", {4'h0, anodo}, 8'h0E);
        chk("e1 segmentos", {1'b0, segmentos}, {1'b0, S4});
        tick();
        chk("e2 anodo", {4'h0, anodo}, 8'h0F);
        chk("e2 segmentos", {1'b0, segmentos}, {1'b0, S3});
        repeat (2000) @(posedge clk);
        #1;
        chk("hold anodo", {4'h0, anodo}, 8'h0D);
        chk("hold segmentos", {1'b0, segmentos}, {1'b0, S3});

        step("p10", 1'b0, 4'b1011, S2, 1'b0);
        skip(3);
        step("p14", 1'b0, 4'b1011, S2, 1'b0);
        valor = 16'h5678;
        step("tear d3", 1'b0, 4'b0111, S1, 1'b1);
        step("new d0",  1'b0, 4'b1110, S8, 1'b1);
        step("new d1",  1'b0, 4'b1101, S7, 1'b1);
        step("new d2",  1'b0, 4'b1011, S6, 1'b0);
        step("new d3",  1'b0, 4'b0111, S5, 1'b1);

        valor       = 16'h0050;
        apaga_zeros = 1'b1;
        step("lz d0", 1'b0, 4'b1110, S0, 1'b1);
        step("lz d1", 1'b0, 4'b1101, S5, 1'b1);
        step("lz d2", 1'b0, 4'b1111, SB, 1'b1);
        valor = 16'h0000;
        step("lz d3", 1'b0, 4'b1111, SB, 1'b1);
        step("zero d0", 1'b0, 4'b1110, S0, 1'b1);
        step("zero d1", 1'b0, 4'b1111, SB, 1'b1);
        skip(2);

        // Blink on digit 0; the time pulse re-evaluates the currently shown digit
        apaga_zeros = 1'b0;
        pisca       = 4'b0001;
        rise(1'b0, 1'b1);
        chk("blink d3 anodo", {4'h0, anodo}, 8'h07);
        chk("blink d3 segmentos", {1'b0, segmentos}, {1'b0, S0});
        step("blink odd d0", 1'b0, 4'b1111, SB, 1'b1);
        rise(1'b0, 1'b1);
        chk("blink even anodo", {4'h0, anodo}, 8'h0E);
        chk("blink even segmentos", {1'b0, segmentos}, {1'b0, S0});
        rise(1'b0, 1'b1);
        chk("blink odd3 anodo", {4'h0, anodo}, 8'h0F);
        chk("blink odd3 segmentos", {1'b0, segmentos}, {1'b0, SB});
        rise(1'b0, 1'b1);
        chk("blink even4 anodo", {4'h0, anodo}, 8'h0E);
        skip(3);
        step("simult d0", 1'b1, 4'b1111, SB, 1'b1);

        // Invalid BCD dash, then reset in the middle of a guard interval
        pisca       = 4'b0000;
        valor       = 16'hA000;
        apaga_zeros = 1'b1;
        skip(3);
        step("dash d0", 1'b0, 4'b1110, S0, 1'b1);
        skip(2);
        step("dash d3", 1'b0, 4'b0111, SD, 1'b1);
        skip(1);
        rise(1'b1, 1'b0);
        chk("pre-reset anodo", {4'h0, anodo}, 8'h0F);
        chk("pre-reset segmentos", {1'b0, segmentos}, {1'b0, S0});
        @(negedge clk);
        rst_n           = 1'b0;
        saida_multiplex = 1'b0;
        #1;
        chk("midreset anodo", {4'h0, anodo}, 8'h0F);
        chk("midreset segmentos", {1'b0, segmentos}, {1'b0, SB});
        chk("midreset ponto", {7'h00, ponto}, 8'h01);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step("post d1", 1'b0, 4'b1111, SB, 1'b1);
        step("post d2", 1'b0, 4'b1111, SB, 1'b1);
        skip(1);
        step("post d0", 1'b0, 4'b1110, S0, 1'b1);
        skip(2);
        step("post d3", 1'b0, 4'b0111, SD, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
